// File: rtl/irs_model_pkg.sv
// Shared constants, FSM state type and target arithmetic for the IRS Wilkinson
// digitizer models.
package irs_model_pkg;

  localparam int NCH_DEF   = 8;
  localparam int NBITS_DEF = 12;
  localparam int DIV_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RAMP = 2'd1,
    DONE = 2'd2
  } state_t;

  // Adds two levels one bit wider than the result, clamping to 2^nbits-1 so a
  // large pedestal pins the channel at full scale instead of wrapping.
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input int unsigned nbits);
    logic [32:0] sum;
    logic [32:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = (33'd1 << nbits) - 33'd1;
    return (sum > lim) ? lim[31:0] : sum[31:0];
  endfunction

endpackage

// File: rtl/irs_wilk_prescaler.sv
// Reloadable down-counter that emits one tick every div_i+1 enabled clocks;
// div_i is sampled only on load and on each reload.
module irs_wilk_prescaler #(
  parameter int DIV_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             tick_o
);

  logic [DIV_W-1:0] cnt_q;

  assign tick_o = en_i && (cnt_q == '0);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= div_i;
    end else if (en_i) begin
      cnt_q <= tick_o ? div_i : cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/irs_wilkinson_array.sv
// Multi-channel Wilkinson conversion engine: one shared ramp counter is
// compared against every channel's pedestal-shifted level.
module irs_wilkinson_array
  import irs_model_pkg::*;
#(
  parameter int NCH   = NCH_DEF,
  parameter int NBITS = NBITS_DEF,
  parameter int DIV_W = DIV_W_DEF,
  localparam int RDW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 clr_i,
  input  logic [DIV_W-1:0]     div_i,
  input  logic [NBITS-1:0]     ped_i,
  input  logic [NCH*NBITS-1:0] sample_i,
  input  logic [RDW-1:0]       rd_ch_i,
  input  logic                 doe_i,
  output logic [NBITS-1:0]     dat_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [NCH-1:0]       ovf_o,
  output logic                 tstout_o
);

  localparam logic [NBITS-1:0] FULL  = '1;
  localparam logic [RDW:0]     NCH_L = (RDW + 1)'(NCH);

  state_t           state_q, state_d;
  logic [NBITS-1:0] counter_q;
  logic [NBITS-1:0] counter_next;
  logic             tick;
  logic             accept;
  logic             ch_clear;
  logic             last_tick;
  logic             all_next;
  logic [NCH-1:0]   latched;
  logic [NCH-1:0]   hit;
  logic [NCH-1:0]   ovf;
  logic [NBITS-1:0] values [NCH];

  assign accept       = (state_q == IDLE) && start_i && !clr_i;
  assign ch_clear     = clr_i || accept;
  assign counter_next = counter_q + 1'b1;
  assign last_tick    = (counter_next == FULL);
  assign all_next     = &(latched | hit);

  irs_wilk_prescaler #(
    .DIV_W(DIV_W)
  ) u_prescaler (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (clr_i),
    .load_i(accept),
    .en_i  (state_q == RAMP),
    .div_i (div_i),
    .tick_o(tick)
  );

  for (genvar k = 0; k < NCH; k++) begin : g_chan
    logic [NBITS-1:0] target;
    logic [NBITS-1:0] value_q;
    logic             latched_q;
    logic             ovf_q;

    assign target = NBITS'(sat_add(32'(sample_i[k*NBITS +: NBITS]), 32'(ped_i), NBITS));
    // The last tick always carries all-ones, so every late channel captures
    // counter_next; it is an overflow exactly when the compare never fired.
    assign hit[k] = tick && !latched_q && ((counter_next > target) || last_tick);

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        value_q   <= '0;
        latched_q <= 1'b0;
        ovf_q     <= 1'b0;
      end else if (ch_clear) begin
        value_q   <= '0;
        latched_q <= 1'b0;
        ovf_q     <= 1'b0;
      end else if (hit[k]) begin
        value_q   <= counter_next;
        latched_q <= 1'b1;
        ovf_q     <= (counter_next <= target);
      end
    end

    assign latched[k] = latched_q;
    assign ovf[k]     = ovf_q;
    assign values[k]  = value_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      counter_q <= '0;
    end else begin
      state_q <= state_d;
      if (ch_clear) begin
        counter_q <= '0;
      end else if (tick) begin
        counter_q <= counter_next;
      end
    end
  end

  // NOTE: state_d is defaulted before the case so no path leaves it
  // unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    if (clr_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start_i) state_d = RAMP;
        RAMP:    if (tick && (last_tick || all_next)) state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dat_o <= '0;
    end else if (doe_i && ({1'b0, rd_ch_i} < NCH_L)) begin
      dat_o <= values[rd_ch_i];
    end else begin
      dat_o <= '0;
    end
  end

  assign busy_o   = (state_q == RAMP);
  assign done_o   = (state_q == DONE);
  assign ovf_o    = ovf;
  assign tstout_o = counter_q[NBITS-1];

endmodule

// File: tb/tb_irs_wilkinson_array.sv
// Directed and randomized bench for irs_wilkinson_array against a per-channel
// arithmetic model of the conversion result and its timing.
module tb_irs_wilkinson_array;

  localparam int NCH   = 8;
  localparam int NBITS = 12;
  localparam int DIV_W = 8;
  localparam int RDW   = 3;
  localparam int FULL  = (1 << NBITS) - 1;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic                 clr;
  logic [DIV_W-1:0]     div;
  logic [NBITS-1:0]     ped;
  logic [NCH*NBITS-1:0] sample;
  logic [RDW-1:0]       rd_ch;
  logic                 doe;
  logic [NBITS-1:0]     dat_o;
  logic                 busy_o;
  logic                 done_o;
  logic [NCH-1:0]       ovf_o;
  logic                 tstout_o;

  int             n_checks = 0;
  int             n_errors = 0;
  int             samp    [NCH];
  int             exp_val [NCH];
  logic [NCH-1:0] exp_ovf;
  int             final_tick;

  irs_wilkinson_array #(
    .NCH  (NCH),
    .NBITS(NBITS),
    .DIV_W(DIV_W)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (start),
    .clr_i   (clr),
    .div_i   (div),
    .ped_i   (ped),
    .sample_i(sample),
    .rd_ch_i (rd_ch),
    .doe_i   (doe),
    .dat_o   (dat_o),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .ovf_o   (ovf_o),
    .tstout_o(tstout_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // A channel with target T below full scale ends at T+1 on tick T+1;
  // a saturated target reads full scale with its overflow flag set.
  task automatic model(input int ped_v);
    final_tick = 0;
    for (int k = 0; k < NCH; k++) begin
      int t;
      t = samp[k] + ped_v;
      if (t >= FULL) begin
        exp_val[k] = FULL;
        exp_ovf[k] = 1'b1;
      end else begin
        exp_val[k] = t + 1;
        exp_ovf[k] = 1'b0;
      end
      if (exp_val[k] > final_tick) final_tick = exp_val[k];
    end
  endtask

  task automatic apply_samples();
    for (int k = 0; k < NCH; k++) sample[k*NBITS +: NBITS] = NBITS'(samp[k]);
  endtask

  task automatic run_conv(input string name, input int div_v, input int ped_v, input int mon);
    int exp_done, done_c, n_done, busy_cnt, first_dat, first_dat_val, first_tst, budget;
    model(ped_v);
    exp_done = final_tick * (div_v + 1) + 1;
    budget   = exp_done + 20;
    div   = DIV_W'(div_v);
    ped   = NBITS'(ped_v);
    apply_samples();
    rd_ch = RDW'(mon);
    doe   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    done_c = -1; n_done = 0; busy_cnt = 0;
    first_dat = -1; first_dat_val = -1; first_tst = -1;
    check({name, " busy at cycle 1"}, 32'(busy_o), 1);
    for (int c = 1; c <= budget; c++) begin
      if (done_o) begin
        n_done++;
        if (done_c < 0) begin
          done_c = c;
          check({name, " ovf at done"}, 32'(ovf_o), 32'(exp_ovf));
          check({name, " busy low at done"}, 32'(busy_o), 0);
        end
      end
      if (busy_o) busy_cnt++;
      if (c >= 2 && dat_o != '0 && first_dat < 0) begin
        first_dat     = c;
        first_dat_val = int'(dat_o);
      end
      if (tstout_o && first_tst < 0) first_tst = c;
      if (done_c >= 0 && c >= done_c + 2) break;
      @(negedge clk);
    end
    check({name, " done cycle"}, done_c, exp_done);
    check({name, " done pulses"}, n_done, 1);
    check({name, " busy cycles"}, busy_cnt, exp_done - 1);
    check({name, " latch visible cycle"}, first_dat, exp_val[mon] * (div_v + 1) + 2);
    check({name, " latch visible value"}, first_dat_val, exp_val[mon]);
    check({name, " tstout rise"}, first_tst,
          (final_tick >= (1 << (NBITS - 1))) ? (1 << (NBITS - 1)) * (div_v + 1) + 1 : -1);
    for (int k = 0; k < NCH; k++) begin
      rd_ch = RDW'(k);
      doe   = 1'b1;
      @(negedge clk);
      check($sformatf("%s read ch%0d", name, k), 32'(dat_o), exp_val[k]);
    end
    doe = 1'b0;
    @(negedge clk);
    check({name, " doe low"}, 32'(dat_o), 0);
    check({name, " ovf hold"}, 32'(ovf_o), 32'(exp_ovf));
  endtask

  initial begin
    int n_done;
    rst = 1'b1; start = 1'b0; clr = 1'b0; div = '0; ped = '0;
    sample = '0; rd_ch = '0; doe = 1'b0;
    repeat (2) @(negedge clk);
    check("por dat", 32'(dat_o), 0);
    check("por busy", 32'(busy_o), 0);
    check("por done", 32'(done_o), 0);
    check("por ovf", 32'(ovf_o), 0);
    check("por tstout", 32'(tstout_o), 0);
    rst = 1'b0;
    @(negedge clk);

    // Single channel against full-scale neighbours.
    for (int k = 0; k < NCH; k++) samp[k] = FULL;
    samp[0] = 100;
    run_conv("single", 3, 0, 0);
    check("single ovf pattern", 32'(exp_ovf), 32'h0000_00FE);

    // Pedestal saturation and its just-below counterpart.
    for (int k = 0; k < NCH; k++) samp[k] = 0;
    samp[3] = 4000;
    run_conv("ped sat", 0, 200, 3);
    samp[3] = 3800;
    run_conv("ped nosat", 0, 200, 3);

    for (int k = 0; k < NCH; k++) samp[k] = 10;
    run_conv("early exit", 0, 0, 5);

    for (int k = 0; k < NCH; k++) samp[k] = 10 * k;
    run_conv("readout", 1, 0, 7);

    // Asynchronous reset in the middle of a ramp.
    for (int k = 0; k < NCH; k++) samp[k] = 2000;
    div = 8'd3; ped = '0; apply_samples(); rd_ch = '0; doe = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (199) @(negedge clk);
    check("pre-reset busy", 32'(busy_o), 1);
    rst = 1'b1;
    #1;
    check("mid reset dat", 32'(dat_o), 0);
    check("mid reset busy", 32'(busy_o), 0);
    check("mid reset done", 32'(done_o), 0);
    check("mid reset ovf", 32'(ovf_o), 0);
    check("mid reset tstout", 32'(tstout_o), 0);
    @(negedge clk);
    rst = 1'b0;
    n_done = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done_o) n_done++;
    end
    check("after reset done count", n_done, 0);
    check("after reset busy", 32'(busy_o), 0);

    // Clear with simultaneous start at tick 50; ch0 already latched by then.
    for (int k = 0; k < NCH; k++) samp[k] = 5 + k;
    samp[7] = 3000;
    div = 8'd2; ped = '0; apply_samples(); rd_ch = '0; doe = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (149) @(negedge clk);
    check("pre-clear dat ch0", 32'(dat_o), 6);
    clr = 1'b1; start = 1'b1;
    @(negedge clk);
    clr = 1'b0; start = 1'b0;
    check("clear busy", 32'(busy_o), 0);
    check("clear done", 32'(done_o), 0);
    @(negedge clk);
    check("clear dat ch0", 32'(dat_o), 0);
    check("clear ovf", 32'(ovf_o), 0);
    check("clear tstout", 32'(tstout_o), 0);
    check("clear done later", 32'(done_o), 0);
    run_conv("after clear", 2, 0, 0);

    for (int r = 0; r < 6; r++) begin
      int d, p, m;
      for (int k = 0; k < NCH; k++) samp[k] = int'($urandom_range(0, 400));
      d = int'($urandom_range(0, 3));
      p = int'($urandom_range(0, 60));
      m = int'($urandom_range(0, NCH - 1));
      run_conv($sformatf("rand%0d", r), d, p, m);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
